// File: rtl/sha_host.sv
// Host-side driver for a sha core: gathers an Nl-byte message, starts the core, streams the digest.
// Optional WAIT timeout enabled by defining SHA_HOST_TIMEOUT_EN.
module sha_host #(
  parameter int unsigned Nl      = 3,
  parameter int unsigned Nk      = 256,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    In_Data,
  input  logic          In_Valid,
  output logic          In_Ready,
  output logic [7:0]    Sha_Data [0:Nl-1],
  output logic          Sha_Enable,
  input  logic [Nk-1:0] Sha_Hash,
  input  logic          Sha_Ready,
  output logic [7:0]    Out_Data,
  output logic          Out_Valid,
  input  logic          Out_Ready,
  output logic          Out_Last,
  output logic          Busy,
  output logic          Error
);

  localparam int unsigned NumBytes = Nk / 8;
  localparam int unsigned WcntW    = (Nl > 1) ? $clog2(Nl) : 1;
  localparam int unsigned RcntW    = (NumBytes > 1) ? $clog2(NumBytes) : 1;

  typedef enum logic [1:0] {StLoad, StStart, StWait, StSend} state_e;

  state_e           state_q, state_d;
  logic [WcntW-1:0] wcnt_q, wcnt_d;
  logic [RcntW-1:0] rcnt_q, rcnt_d;
  logic [Nk-1:0]    digest_q, digest_d;
  logic [7:0]       data_q [0:Nl-1];
  logic             in_xfer;
  logic             timeout;

  assign in_xfer  = In_Valid && In_Ready;
  assign Sha_Data = data_q;
  assign Busy     = (state_q != StLoad);
  assign Out_Data = digest_q[Nk-1 -: 8];
  assign Out_Last = (state_q == StSend) && (rcnt_q == RcntW'(NumBytes - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StLoad;
      wcnt_q   <= '0;
      rcnt_q   <= '0;
      digest_q <= '0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      rcnt_q   <= rcnt_d;
      digest_q <= digest_d;
    end
  end

  // Message array only moves on accepted bytes, so it is stable for the core from START onward.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(Nl); i++) begin
        data_q[i] <= '0;
      end
    end else if (in_xfer) begin
      data_q[wcnt_q] <= In_Data;
    end
  end

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    rcnt_d     = rcnt_q;
    digest_d   = digest_q;
    In_Ready   = 1'b0;
    Sha_Enable = 1'b0;
    Out_Valid  = 1'b0;
    unique case (state_q)
      StLoad: begin
        In_Ready = 1'b1;
        if (In_Valid) begin
          if (wcnt_q == WcntW'(Nl - 1)) begin
            wcnt_d  = '0;
            state_d = StStart;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end
      StStart: begin
        Sha_Enable = 1'b1;
        state_d    = StWait;
      end
      StWait: begin
        if (Sha_Ready) begin
          digest_d = Sha_Hash;
          rcnt_d   = '0;
          state_d  = StSend;
        end else if (timeout) begin
          state_d = StLoad;
        end
      end
      StSend: begin
        Out_Valid = 1'b1;
        if (Out_Ready) begin
          // Shifting MSB-first leaves the register zeroed once the last byte leaves.
          digest_d = digest_q << 8;
          if (Out_Last) begin
            rcnt_d  = '0;
            state_d = StLoad;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
      end
      default: state_d = StLoad;
    endcase
  end

`ifdef SHA_HOST_TIMEOUT_EN
  localparam int unsigned TcntW = $clog2(TIMEOUT + 1);

  logic [TcntW-1:0] tcnt_q;
  logic             error_q;

  assign timeout = (state_q == StWait) && !Sha_Ready && (tcnt_q == TcntW'(TIMEOUT - 1));
  assign Error   = error_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt_q  <= '0;
      error_q <= 1'b0;
    end else begin
      tcnt_q <= (state_q == StWait) ? tcnt_q + 1'b1 : '0;
      if (timeout) begin
        error_q <= 1'b1;
      end else if (in_xfer) begin
        error_q <= 1'b0;
      end
    end
  end
`else
  assign timeout = 1'b0;
  assign Error   = 1'b0;
`endif

endmodule

// File: doc/sha_host.md
# sha_host

Host-side driver for the `sha` top. It collects an Nl-byte message from a byte stream and presents it on `sha`'s `Data` array. It then pulses `sha`'s `Enable`, waits for `Ready`, latches `Hash`, and returns the digest as a byte stream, MSB first. It sits between a byte-oriented source/sink and the `sha` instance, and drives that instance's input side.

## Interface
Parameters:
- `Nl`, 3: message length in bytes, ≥1; must equal `sha`'s Nl.
- `Nk`, 256: digest width in bits, a multiple of 8; must equal `sha`'s Nk.
- `TIMEOUT`, 4096: WAIT-state cycle limit, used only with `SHA_HOST_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `In_Data`  in  8  message byte.
- `In_Valid`  in  1  source has a byte.
- `In_Ready`  out  1  block accepts a byte.
- `Sha_Data`  out  8 × [0:Nl-1]  message array to `sha.Data`.
- `Sha_Enable`  out  1  one-cycle start pulse to `sha.Enable`.
- `Sha_Hash`  in  Nk  from `sha.Hash`.
- `Sha_Ready`  in  1  from `sha.Ready`.
- `Out_Data`  out  8  digest byte.
- `Out_Valid`  out  1  digest byte available.
- `Out_Ready`  in  1  sink accepts a byte.
- `Out_Last`  out  1  qualifies the final digest byte.
- `Busy`  out  1  high in START, WAIT and SEND.
- `Error`  out  1  timeout flag (see Configuration).

## Operation
- A transfer on either stream occurs on a cycle with Valid=1 and Ready=1.
- FSM states: LOAD → START → WAIT → SEND → LOAD.
- **LOAD**
  - `In_Ready`=1.
  - Each transfer writes `In_Data` to `Sha_Data[wcnt]` and increments `wcnt` (0..Nl-1).
  - A transfer with `wcnt`=Nl-1 clears `wcnt` and moves to START.
- **START**
  - `Sha_Enable`=1 for exactly one cycle, then WAIT.
- **WAIT**
  - On `Sha_Ready`=1, latch `Sha_Hash` into the digest shift register, clear `rcnt`, and move to SEND.
  - `Sha_Ready` is ignored in every other state.
- **SEND**
  - `Out_Valid`=1 and `Out_Data` = digest bits [Nk-1-8·rcnt -: 8].
  - `Out_Last` = (`rcnt` == Nk/8-1).
  - Each transfer increments `rcnt`.
  - The transfer with `Out_Last`=1 returns to LOAD.
- `Sha_Data` changes only on LOAD transfers and is stable from START until the next LOAD transfer.
- `Out_Data`/`Out_Valid` hold steady while `Out_Ready`=0.
- `In_Ready`=0 outside LOAD; input bytes offered then are not consumed.

## Timing
- Reset values:
  - state=LOAD, `wcnt`=`rcnt`=0.
  - `In_Ready`=1, `Sha_Enable`=0, `Out_Valid`=0, `Out_Last`=0, `Out_Data`=0, `Busy`=0, `Error`=0.
  - `Sha_Data` all 0, digest register 0.
- Reset asserted mid-operation aborts immediately to the reset values; a pending `sha` result is ignored.
- Minimum load time is Nl cycles with `In_Valid` held high.
- Last input transfer at cycle t:
  - `Sha_Enable`=1 during t+1.
  - WAIT from t+2.
- `Sha_Ready` sampled high at cycle u:
  - `Out_Valid`=1 with digest byte 0 at u+1.
- With `Out_Ready` held high, one byte is sent per cycle: Nk/8 cycles.
- After the last output transfer at cycle v, `In_Ready`=1 at v+1.
- `Sha_Ready` arriving in the same cycle as START is not possible; START always lasts exactly one cycle.

## Configuration
- `SHA_HOST_TIMEOUT_EN` defined:
  - A counter runs in WAIT.
  - If `TIMEOUT` cycles elapse without `Sha_Ready`, set `Error`=1 and return to LOAD with no output.
  - `Error` is sticky until the next LOAD transfer or reset.
- `SHA_HOST_TIMEOUT_EN` undefined:
  - WAIT is unbounded.
  - `Error` is tied to 0 and no counter logic exists.

## Test plan
- Nl=3, Nk=256, bytes 0x61,0x62,0x63 with `sha` attached → 32 output bytes `ba 78 16 bf … f2 00 15 ad`; `Out_Last` only on 0xad; `Sha_Enable` is a single pulse.
- Same message with `Out_Ready` toggling every cycle → identical byte sequence; `Out_Data` stable while stalled; 63 cycles from first `Out_Valid` to last transfer.
- `In_Valid` with gaps (1 of every 3 cycles) → `Sha_Enable` still follows the third accepted byte by exactly 1 cycle; `Sha_Data` = {61,62,63}.
- Model asserts `Sha_Ready` during LOAD and during SEND → no state change, no digest overwrite.
- With `SHA_HOST_TIMEOUT_EN`, `TIMEOUT`=16 and `Sha_Ready` never asserted → `Error`=1 exactly 16 cycles after entering WAIT; `In_Ready`=1; `Error` clears on the next input transfer.
- `rst` pulsed while `rcnt`=5 in SEND → `Out_Valid`=0 and `In_Ready`=1 immediately; the next full message produces a complete 32-byte digest.
